// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage register file.
//
// Selects the write-back value (load data or ALU result), commits it to the
// general-purpose register file and serves the two decode-stage read ports.
// A write retiring this cycle is bypassed straight onto any read port that
// addresses the same register, so ID never sees stale data. A free-running
// counter tracks committed writes since reset.
//
// Ports:
//   clk_i        pipeline clock, state updates on rising edge
//   rst_i        asynchronous active-high reset
//   mem_i        load data from MEM/WB
//   ALUResult_i  ALU result from MEM/WB
//   RDaddr_i     destination register from MEM/WB
//   RegWrite_i   write enable from MEM/WB
//   MemtoReg_i   1 selects mem_i, 0 selects ALUResult_i
//   RS1addr_i    read port 1 address
//   RS2addr_i    read port 2 address
//   RS1data_o    read port 1 data
//   RS2data_o    read port 2 data
//   WBdata_o     selected write-back value (feeds EX forwarding)
//   wb_count_o   committed register writes since reset (wraps)
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [ADDR_W-1:0] RS1addr_i,
    input  logic [ADDR_W-1:0] RS2addr_i,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic [31:0]       wb_count_o
);

    localparam int NumRegs = 1 << ADDR_W;

    // Entry 0 exists only to keep indexing simple; it is never written and
    // never read out.
    logic [DATA_W-1:0] regs_q [NumRegs];
    logic [31:0]       wb_count_q;
    logic [DATA_W-1:0] wb_data;
    logic              we;

    assign wb_data = MemtoReg_i ? mem_i : ALUResult_i;
    assign WBdata_o = wb_data;

    // rst_i gates the enable so a write presented during reset is dropped.
    assign we = RegWrite_i && (RDaddr_i != '0) && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[RDaddr_i] <= wb_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_count_q <= '0;
        end else if (we) begin
            wb_count_q <= wb_count_q + 32'd1;
        end
    end

    assign wb_count_o = wb_count_q;

    // Read port 1: reset and r0 force zero, then same-cycle bypass, then array.
    always_comb begin
        RS1data_o = '0;
        if (rst_i || (RS1addr_i == '0)) begin
            RS1data_o = '0;
        end else if (we && (RS1addr_i == RDaddr_i)) begin
            RS1data_o = wb_data;
        end else begin
            RS1data_o = regs_q[RS1addr_i];
        end
    end

    // Read port 2: identical priority, independent of port 1.
    always_comb begin
        RS2data_o = '0;
        if (rst_i || (RS2addr_i == '0)) begin
            RS2data_o = '0;
        end else if (we && (RS2addr_i == RDaddr_i)) begin
            RS2data_o = wb_data;
        end else begin
            RS2data_o = regs_q[RS2addr_i];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
// Inputs change 1 ns after the rising edge; outputs are sampled before the
// next edge.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    int checks;
    int errors;
    logic [31:0] exp_count;

    wb_regfile #(
        .DATA_W(32),
        .ADDR_W(5)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mem_i      (mem),
        .ALUResult_i(alu),
        .RDaddr_i   (rd),
        .RegWrite_i (reg_write),
        .MemtoReg_i (mem_to_reg),
        .RS1addr_i  (rs1),
        .RS2addr_i  (rs2),
        .RS1data_o  (rs1_data),
        .RS2data_o  (rs2_data),
        .WBdata_o   (wb_data),
        .wb_count_o (wb_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Present one write for a single cycle; called 1 ns after a rising edge.
    task automatic do_write(input logic [4:0] a, input logic sel,
                            input logic [31:0] m, input logic [31:0] r);
        reg_write  = 1'b1;
        rd         = a;
        mem_to_reg = sel;
        mem        = m;
        alu        = r;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        if (a != 5'd0) exp_count = exp_count + 32'd1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_reads: rs1=%h rs2=%h expected 0", rs1_data, rs2_data);
        end
        checks++;
        if (wb_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_count: got %h expected 0", wb_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_count = 32'h0;
    endtask

    task automatic test_basic;
        do_write(5'd7, 1'b0, 32'h0, 32'h1234_5678);
        rs1 = 5'd7;
        #1;
        checks++;
        if (rs1_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL basic_read: got %h expected 12345678", rs1_data);
        end
        checks++;
        if (wb_count !== 32'd1) begin
            errors++;
            $display("FAIL basic_count: got %h expected 1", wb_count);
        end
    endtask

    task automatic test_mux;
        mem_to_reg = 1'b1;
        mem        = 32'hDEAD_BEEF;
        alu        = 32'h1;
        #1;
        checks++;
        if (wb_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mux_mem: got %h expected deadbeef", wb_data);
        end
        mem_to_reg = 1'b0;
        #1;
        checks++;
        if (wb_data !== 32'h1) begin
            errors++;
            $display("FAIL mux_alu: got %h expected 1", wb_data);
        end
        @(posedge clk);
        #1;
        do_write(5'd3, 1'b1, 32'hDEAD_BEEF, 32'h1);
        rs2 = 5'd3;
        #1;
        checks++;
        if (rs2_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mux_read_r3: got %h expected deadbeef", rs2_data);
        end
    endtask

    task automatic test_bypass;
        do_write(5'd9, 1'b0, 32'h0, 32'hAAAA_0000);
        rs1        = 5'd9;
        rs2        = 5'd9;
        reg_write  = 1'b1;
        rd         = 5'd9;
        mem_to_reg = 1'b0;
        alu        = 32'h5555_FFFF;
        #1;
        checks++;
        if (rs1_data !== 32'h5555_FFFF || rs2_data !== 32'h5555_FFFF) begin
            errors++;
            $display("FAIL bypass_hit: rs1=%h rs2=%h expected 5555ffff", rs1_data, rs2_data);
        end
        reg_write = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'hAAAA_0000 || rs2_data !== 32'hAAAA_0000) begin
            errors++;
            $display("FAIL bypass_off: rs1=%h rs2=%h expected aaaa0000", rs1_data, rs2_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rs1_data !== 32'hAAAA_0000 || wb_count !== exp_count) begin
            errors++;
            $display("FAIL bypass_no_commit: rs1=%h cnt=%h expected aaaa0000 cnt=%h",
                     rs1_data, wb_count, exp_count);
        end
    endtask

    task automatic test_zero_reg;
        reg_write  = 1'b1;
        rd         = 5'd0;
        mem_to_reg = 1'b0;
        alu        = 32'hFFFF_FFFF;
        rs1        = 5'd0;
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            errors++;
            $display("FAIL zero_in_cycle: got %h expected 0", rs1_data);
        end
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || wb_count !== exp_count) begin
            errors++;
            $display("FAIL zero_after: rs1=%h cnt=%h expected 0 cnt=%h",
                     rs1_data, wb_count, exp_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals [3];
        vals[0] = 32'h0000_0011;
        vals[1] = 32'h0000_0022;
        vals[2] = 32'h0000_0033;
        rs1 = 5'd12;
        for (int i = 0; i < 3; i++) begin
            reg_write  = 1'b1;
            rd         = 5'd12;
            mem_to_reg = 1'b0;
            alu        = vals[i];
            #1;
            checks++;
            if (rs1_data !== vals[i]) begin
                errors++;
                $display("FAIL b2b_bypass[%0d]: got %h expected %h", i, rs1_data, vals[i]);
            end
            @(posedge clk);
            #1;
            exp_count = exp_count + 32'd1;
        end
        reg_write = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'h0000_0033 || wb_count !== exp_count) begin
            errors++;
            $display("FAIL b2b_final: rs1=%h cnt=%h expected 33 cnt=%h",
                     rs1_data, wb_count, exp_count);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 1'b0, 32'h0, 32'h0101_0101 * 32'(i));
        end
        rs1 = 5'd5;
        rs2 = 5'd31;
        #1;
        checks++;
        if (rs1_data !== 32'h0505_0505 || rs2_data !== 32'h1F1F_1F1F || wb_count !== 32'd37) begin
            errors++;
            $display("FAIL fill: rs1=%h rs2=%h cnt=%h expected 05050505 1f1f1f1f 25",
                     rs1_data, rs2_data, wb_count);
        end
        // In-flight write to r5 when reset hits mid-cycle.
        reg_write  = 1'b1;
        rd         = 5'd5;
        mem_to_reg = 1'b0;
        alu        = 32'h0000_0BAD;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || wb_count !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: rs1=%h rs2=%h cnt=%h expected 0 0 0",
                     rs1_data, rs2_data, wb_count);
        end
        checks++;
        if (wb_data !== 32'h0000_0BAD) begin
            errors++;
            $display("FAIL mid_reset_wbdata: got %h expected 00000bad", wb_data);
        end
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        rst       = 1'b0;
        exp_count = 32'h0;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || wb_count !== 32'h0) begin
            errors++;
            $display("FAIL post_reset: rs1=%h rs2=%h cnt=%h expected 0 0 0",
                     rs1_data, rs2_data, wb_count);
        end
        do_write(5'd5, 1'b1, 32'hCAFE_0005, 32'h0);
        checks++;
        if (rs1_data !== 32'hCAFE_0005 || wb_count !== 32'd1) begin
            errors++;
            $display("FAIL first_write: rs1=%h cnt=%h expected cafe0005 1", rs1_data, wb_count);
        end
    endtask

    task automatic test_counter_wrap;
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hFFFF_FFFF;
        exp_seq[1] = 32'h0000_0000;
        exp_seq[2] = 32'h0000_0001;
        force dut.wb_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.wb_count_q;
        #1;
        checks++;
        if (wb_count !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL wrap_preload: got %h expected fffffffe", wb_count);
        end
        for (int i = 0; i < 3; i++) begin
            do_write(5'd20, 1'b0, 32'h0, 32'(i));
            checks++;
            if (wb_count !== exp_seq[i]) begin
                errors++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, wb_count, exp_seq[i]);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_count  = 32'h0;
        rst        = 1'b0;
        mem        = 32'h0;
        alu        = 32'h0;
        rd         = 5'd0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        rs1        = 5'd0;
        rs2        = 5'd0;
        @(posedge clk);
        #1;
        test_reset;
        test_basic;
        test_mux;
        test_bypass;
        test_zero_reg;
        test_back_to_back;
        test_reset_mid;
        test_counter_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
